aes_key_sched_ctrl: RTL and testbench

Sequencer for AES-128 key expansion. It walks the combinational `aes_key_xor` stage through rounds 1–10 and holds the working key register. It requests SubWord results from a shared S-box port over a req/ack handshake. Round keys 0–10 are emitted in order on a valid/ready stream for the cipher datapath.

---
 rtl/aes_key_sched_ctrl.sv | 157 +++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: walks aes_key_xor through rounds 1..NR and streams round keys.
// Optional reverse-order replay of the last expansion when AES_KEY_SCHED_REPLAY_EN is defined.
module aes_key_sched_ctrl #(
  parameter int unsigned NR   = 10,
  parameter int unsigned RD_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [127:0]    key_in,
`ifdef AES_KEY_SCHED_REPLAY_EN
  input  logic            replay,
`endif
  output logic            busy,
  output logic            done,
  output logic            sbox_req,
  output logic [31:0]     sbox_word,
  input  logic            sbox_ack,
  input  logic [31:0]     sbox_out,
  output logic [RD_W-1:0] RD,
  output logic [31:0]     keyBox_out,
  output logic [127:0]    old_key,
  input  logic [127:0]    new_key,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [127:0]    round_key,
  output logic [RD_W-1:0] rk_round
);

  typedef enum logic [2:0] {StIdle, StEmit, StSub, StXor, StDone} state_e;

  state_e          state_q, state_d;
  logic [127:0]    key_q, key_d;
  logic [31:0]     sbox_q, sbox_d;
  logic [RD_W-1:0] round_q, round_d;

`ifdef AES_KEY_SCHED_REPLAY_EN
  logic [127:0] store_q [NR+1];
  logic         replay_q, replay_d;
  logic         exp_valid_q, exp_valid_d;
  logic         store_we;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      key_q   <= '0;
      sbox_q  <= '0;
      round_q <= '0;
`ifdef AES_KEY_SCHED_REPLAY_EN
      replay_q    <= 1'b0;
      exp_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      sbox_q  <= sbox_d;
      round_q <= round_d;
`ifdef AES_KEY_SCHED_REPLAY_EN
      replay_q    <= replay_d;
      exp_valid_q <= exp_valid_d;
`endif
    end
  end

`ifdef AES_KEY_SCHED_REPLAY_EN
  // Key store is not reset; exp_valid_q alone gates its use.
  always_ff @(posedge clk) begin
    if (store_we) store_q[round_q] <= key_q;
  end
`endif

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    sbox_d    = sbox_q;
    round_d   = round_q;
    busy      = 1'b0;
    done      = 1'b0;
    sbox_req  = 1'b0;
    sbox_word = '0;
    RD        = '0;
    rk_valid  = 1'b0;
`ifdef AES_KEY_SCHED_REPLAY_EN
    replay_d    = replay_q;
    exp_valid_d = exp_valid_q;
    store_we    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = key_in;
          round_d = '0;
          state_d = StEmit;
`ifdef AES_KEY_SCHED_REPLAY_EN
          replay_d = 1'b0;
        end else if (replay && exp_valid_q) begin
          key_d    = store_q[NR];
          round_d  = RD_W'(NR);
          replay_d = 1'b1;
          state_d  = StEmit;
`endif
        end
      end
      StEmit: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready) begin
`ifdef AES_KEY_SCHED_REPLAY_EN
          store_we = !replay_q;
          if (replay_q) begin
            if (round_q == '0) begin
              state_d = StDone;
            end else begin
              round_d = round_q - RD_W'(1);
              key_d   = store_q[round_d];
            end
          end else
`endif
          if (round_q == RD_W'(NR)) state_d = StDone;
          else                      state_d = StSub;
        end
      end
      StSub: begin
        busy      = 1'b1;
        sbox_req  = 1'b1;
        sbox_word = {key_q[23:0], key_q[31:24]};
        if (sbox_ack) begin
          sbox_d  = sbox_out;
          state_d = StXor;
        end
      end
      StXor: begin
        busy    = 1'b1;
        RD      = round_q + RD_W'(1);
        key_d   = new_key;
        round_d = round_q + RD_W'(1);
        state_d = StEmit;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
`ifdef AES_KEY_SCHED_REPLAY_EN
        if (!replay_q) exp_valid_d = 1'b1;
        replay_d = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign keyBox_out = sbox_q;
  assign old_key    = key_q;
  assign round_key  = key_q;
  assign rk_round   = round_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: emulates the S-box and aes_key_xor, checks against a full key expansion.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, rk_ready, ack_en;
  logic [127:0] key_in;
`ifdef AES_KEY_SCHED_REPLAY_EN
  logic         replay;
`endif
  logic         busy, done, sbox_req, sbox_ack, rk_valid;
  logic [31:0]  sbox_word, sbox_out, keyBox_out;
  logic [3:0]   RD, rk_round;
  logic [127:0] old_key, new_key, round_key;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_keys [11];
  logic [127:0] cap_keys [11];
  int           exp_round = 0;
  int           exp_dir = 1;
  bit           exp_active = 0;
  bit           replay_mode = 0;
  int           start_cnt = 0;
  int           replay_cnt = 0;
  logic [127:0] start_key;
  int           rdy_prob = 100, ack_prob = 100, rdy_hold = 0, ack_hold = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, p, s;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    if (x == 8'h00) r = 8'h00;
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = gmul(c, 8'h02);
    return c;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] k, input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Stand-in for aes_key_xor, driven only from the DUT's outputs.
  assign new_key  = mix(old_key, keyBox_out ^ {rcon(int'(RD)), 24'h0});
  assign sbox_out = sub_word(sbox_word);
  assign sbox_ack = ack_en;

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_in     (key_in),
`ifdef AES_KEY_SCHED_REPLAY_EN
    .replay     (replay),
`endif
    .busy       (busy),
    .done       (done),
    .sbox_req   (sbox_req),
    .sbox_word  (sbox_word),
    .sbox_ack   (sbox_ack),
    .sbox_out   (sbox_out),
    .RD         (RD),
    .keyBox_out (keyBox_out),
    .old_key    (old_key),
    .new_key    (new_key),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .round_key  (round_key),
    .rk_round   (rk_round)
  );

  task automatic chk(input bit ok, input string name, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [127:0] key_at(input int i);
    if (i < 0 || i > 10) return '0;
    return exp_keys[i];
  endfunction

  task automatic monitor();
    bit           stall_rk = 0, stall_sb = 0;
    logic [127:0] p_key = '0, k_prev;
    logic [3:0]   p_rnd = '0;
    logic [31:0]  p_sw = '0;
    int           seen_s = 0, seen_r = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_rk = 0;
        stall_sb = 0;
        exp_active = 0;
        replay_mode = 0;
        continue;
      end
      if (start_cnt != seen_s) begin
        seen_s = start_cnt;
        exp_keys[0] = start_key;
        for (int r = 1; r <= 10; r++)
          exp_keys[r] = mix(exp_keys[r-1],
                            sub_word(rot_word(exp_keys[r-1][31:0])) ^ {rcon(r), 24'h0});
        exp_round = 0;
        exp_dir = 1;
        exp_active = 1;
        replay_mode = 0;
      end
      if (replay_cnt != seen_r) begin
        seen_r = replay_cnt;
        exp_round = 10;
        exp_dir = -1;
        exp_active = 1;
        replay_mode = 1;
      end
      chk(old_key == round_key, "old_key_vs_round_key", old_key, round_key);
      if (stall_rk)
        chk(rk_valid && rk_round == p_rnd && round_key == p_key, "rk_payload_stable",
            round_key, p_key);
      if (stall_sb)
        chk(sbox_req && sbox_word == p_sw, "sbox_payload_stable", sbox_word, p_sw);
      k_prev = key_at(exp_round - 1);
      if (rk_valid) begin
        chk(exp_active && busy && !sbox_req, "rk_valid_context", rk_valid, exp_active);
        chk(int'(rk_round) == exp_round, "rk_round", rk_round, exp_round);
        chk(round_key == key_at(exp_round), "round_key", round_key, key_at(exp_round));
        if (rk_ready) begin
          if (exp_round >= 0 && exp_round <= 10) cap_keys[exp_round] = round_key;
          exp_round += exp_dir;
        end
      end
      if (sbox_req) begin
        chk(exp_active && busy && !replay_mode, "sbox_req_context", sbox_req, 1'b0);
        chk(sbox_word == rot_word(k_prev[31:0]), "sbox_word", sbox_word,
            rot_word(k_prev[31:0]));
      end
      if (RD != 4'd0) begin
        chk(!replay_mode && int'(RD) == exp_round, "RD", RD, exp_round);
        chk(keyBox_out == sub_word(rot_word(k_prev[31:0])), "keyBox_out", keyBox_out,
            sub_word(rot_word(k_prev[31:0])));
      end
      if (done) begin
        chk(exp_active && exp_round == (replay_mode ? -1 : 11), "done_after_last_key",
            exp_round, replay_mode ? -1 : 11);
        exp_active = 0;
        replay_mode = 0;
      end
      stall_rk = rk_valid && !rk_ready;
      stall_sb = sbox_req && !sbox_ack;
      p_key = round_key;
      p_rnd = rk_round;
      p_sw  = sbox_word;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_hold > 0) begin
      rk_ready = 1'b0;
      rdy_hold--;
    end else rk_ready = ($urandom_range(99) < rdy_prob);
    if (ack_hold > 0) begin
      ack_en = 1'b0;
      ack_hold--;
    end else ack_en = ($urandom_range(99) < ack_prob);
  endtask

  task automatic do_start(input logic [127:0] k);
    start = 1'b1;
    key_in = k;
    start_key = k;
    start_cnt++;
  endtask

  // Runs until done (or reset at rst_rd); the first tick is the edge that accepts start/replay.
  task automatic run_body(input int bp_rd, input int ack_rd, input int sb_rd, input int rst_rd,
                          output int cycles);
    bit bp_d = 0, ack_d = 0, sb_d = 0;
    cycles = 0;
    forever begin
      tick();
      cycles++;
      start = 1'b0;
`ifdef AES_KEY_SCHED_REPLAY_EN
      replay = 1'b0;
`endif
      if (done) break;
      if (cycles > 3000) begin
        checks++;
        errors++;
        $display("FAIL run_timeout: got no done after %0d cycles, expected done", cycles);
        break;
      end
      if (rst_rd >= 0 && sbox_req && int'(rk_round) == rst_rd) begin
        ack_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk(!sbox_req && !busy && !rk_valid, "reset_mid_run",
            {sbox_req, busy, rk_valid}, 3'b000);
        break;
      end
      if (bp_rd >= 0 && !bp_d && rk_valid && int'(rk_round) == bp_rd) begin
        bp_d = 1;
        rk_ready = 1'b0;
        rdy_hold = 4;
      end
      if (ack_rd >= 0 && !ack_d && sbox_req && int'(rk_round) == ack_rd) begin
        ack_d = 1;
        ack_en = 1'b0;
        ack_hold = 3;
      end
      if (sb_rd >= 0 && !sb_d && rk_valid && int'(rk_round) == sb_rd) begin
        sb_d = 1;
        start = 1'b1;
        key_in = ~key_in;
      end
    end
  endtask

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsRk1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    int cyc;
    logic [127:0] k2;
    reset = 1'b1;
    start = 1'b0;
    key_in = '0;
    rk_ready = 1'b0;
    ack_en = 1'b0;
`ifdef AES_KEY_SCHED_REPLAY_EN
    replay = 1'b0;
`endif
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk({busy, done, sbox_req, rk_valid} == 4'b0, "reset_flags", {busy, done, sbox_req, rk_valid},
        0);
    chk(RD == 4'd0 && rk_round == 4'd0, "reset_rd_round", {RD, rk_round}, 0);
    chk(sbox_word == 32'd0 && keyBox_out == 32'd0, "reset_sbox", {sbox_word, keyBox_out}, 0);
    chk(round_key == '0 && old_key == '0, "reset_keys", round_key, 0);
    reset = 1'b0;
    tick();

`ifdef AES_KEY_SCHED_REPLAY_EN
    replay = 1'b1;
    tick();
    replay = 1'b0;
    repeat (3) tick();
    chk(!busy && !rk_valid, "replay_before_expansion", {busy, rk_valid}, 0);
`endif

    // FIPS-197 key with an always-ready consumer and same-cycle ack.
    rdy_prob = 100;
    ack_prob = 100;
    tick();
    do_start(FipsKey);
    run_body(-1, -1, -1, -1, cyc);
    chk(cyc == 32, "done_latency", cyc, 32);
    chk(cap_keys[0] == FipsKey, "fips_rk0", cap_keys[0], FipsKey);
    chk(cap_keys[1] == FipsRk1, "fips_rk1", cap_keys[1], FipsRk1);
    chk(cap_keys[10] == FipsRk10, "fips_rk10", cap_keys[10], FipsRk10);
    chk(exp_keys[1] == FipsRk1, "model_rk1", exp_keys[1], FipsRk1);
    chk(exp_keys[10] == FipsRk10, "model_rk10", exp_keys[10], FipsRk10);

`ifdef AES_KEY_SCHED_REPLAY_EN
    tick();
    replay = 1'b1;
    replay_cnt++;
    run_body(-1, -1, -1, -1, cyc);
    chk(cap_keys[0] == FipsKey && cap_keys[10] == FipsRk10, "replay_keys", cap_keys[10],
        FipsRk10);
`endif

    // Start in the done cycle is ignored, then accepted from idle.
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    key_in = k2;
    tick();
    chk(!busy && !rk_valid, "start_in_done_ignored", {busy, rk_valid}, 0);
    rdy_prob = 60;
    ack_prob = 50;
    do_start(k2);
    run_body(-1, -1, -1, -1, cyc);

    // Backpressure, delayed ack and a start while busy.
    rdy_prob = 100;
    ack_prob = 100;
    tick();
    do_start(FipsKey);
    run_body(3, 7, 4, -1, cyc);
    chk(cap_keys[10] == FipsRk10, "backpressure_rk10", cap_keys[10], FipsRk10);

    // Reset during SUB of round 6, then a fresh expansion.
    tick();
    do_start({$urandom, $urandom, $urandom, $urandom});
    run_body(-1, -1, -1, 6, cyc);
    do_start({$urandom, $urandom, $urandom, $urandom});
    run_body(-1, -1, -1, -1, cyc);

    for (int i = 0; i < 4; i++) begin
      rdy_prob = 30 + $urandom_range(70);
      ack_prob = 30 + $urandom_range(70);
      tick();
      do_start({$urandom, $urandom, $urandom, $urandom});
      run_body(-1, -1, -1, -1, cyc);
    end
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
